fetch_decode_stage: RTL and testbench
=====================================

// Module: fetch_decode_stage
// PURPOSE
//  Fetch and decode front end for the LEGv8 datapath. Owns the PC and issues word fetches
//  to instruction memory over a req/ack handshake. Holds one fetched instruction in an
//  ID register and classifies it.
//  Drives Imm25 = instr[25:0] and the 3-bit immediate-type select to the sign-extension
//  block directly downstream. Takes taken-branch redirects back from the execute stage.
// PARAMETERS
//  RESET_PC  64'h0  PC loaded on reset
//  PC_INC    4      byte increment per sequential fetch
// PORTS
//  CLK            in   1   clock, all state updates on posedge
//  Reset_L        in   1   synchronous active-low reset
//  imem_req       out  1   fetch request, held until imem_ack
//  imem_addr      out  64  fetch address, stable while imem_req=1
//  imem_ack       in   1   1-cycle pulse: imem_rdata valid this cycle
//  imem_rdata     in   32  fetched instruction word
//  branch_taken   in   1   redirect request from execute (1-cycle pulse)
//  branch_target  in   64  redirect PC, sampled when branch_taken=1
//  stall          in   1   downstream hold: ID register must not change
//  id_valid       out  1   ID register holds a live instruction
//  id_pc          out  64  PC of ID instruction
//  id_instr       out  32  ID instruction word
//  Imm25          out  26  id_instr[25:0]
//  SignOp         out  3   imm type: 000 I, 001 D, 010 B, 011 CB, 100 R-shamt, 101 IW
// BEHAVIOUR
//  Reset (Reset_L=0 at posedge, wins over all inputs, including mid-fetch):
//   pc=RESET_PC, state=IDLE, imem_req=0, id_valid=0, id_pc=0, id_instr=0, SignOp=100, kill=0.
//   An ack arriving in the reset cycle is dropped.
//  FSM:
//   IDLE -> REQ on the next cycle. imem_req=1, imem_addr=pc.
//   REQ, no ack: stay; addr and req held stable.
//   REQ, ack, kill=0, ID free (stall=0 or id_valid=0):
//    load ID (id_valid=1, id_pc=pc, id_instr=rdata); pc+=PC_INC; stay REQ (back-to-back).
//   REQ, ack, kill=0, ID busy (stall=1 and id_valid=1):
//    capture rdata into a 1-entry skid buffer; pc+=PC_INC; -> HOLD with imem_req=0.
//   REQ, ack, kill=1: discard rdata; kill=0; issue the next request at the redirected pc.
//   HOLD, stall=0: skid -> ID; -> REQ.
//  ID register with no new word and stall=0: id_valid=0 (bubble).
//  Redirect (branch_taken=1):
//   pc=branch_target; id_valid=0; skid cleared.
//   A request outstanding and not acked this cycle sets kill=1.
//   HOLD -> REQ.
//   Redirect overrides stall and a same-cycle ack (that word is discarded).
//  pc arithmetic is modulo 2^64; wrap from 64'hFFFF_FFFF_FFFF_FFFC to 0 is legal, no flag.
//  SignOp decode (combinational from id_instr, priority top-down):
//   [31:26]=000101|100101 -> 010
//   [31:24]=10110100|10110101|01010100 -> 011
//   [31:21]=11111000010|11111000000 -> 001
//   [31:23]=110100101|111100101 -> 101
//   [31:22]=1001000100|1101000100|1001001000|1011001000 -> 000
//   all others (incl. LSL/LSR) -> 100
//  Imm25 = id_instr[25:0] always, including when id_valid=0.
//  Latency: ack cycle -> id_valid on the next posedge (1 cycle).
//  Steady state: one instruction per cycle when ack returns every cycle.
// TESTING
//  1 Reset, ack each cycle with rdata=0x91000421 -> imem_addr 0,4,8...;
//    id_instr=0x91000421, Imm25=26'h1000421, SignOp=000.
//  2 rdata=0x14000004 then 0xD2A24680 -> SignOp 010 with Imm25=26'h0000004,
//    then SignOp 101 with Imm25=26'h2A24680.
//  3 ack delayed 3 cycles -> imem_addr and imem_req held constant for all 3 cycles;
//    id_valid=0 during the wait.
//  4 stall=1 for 2 cycles while acks arrive -> ID unchanged, one word skidded, imem_req=0;
//    after stall drops the ID register gets the skid word with no loss or duplicate.
//  5 branch_taken with target 0x100 while a fetch is pending, ack arrives 2 cycles later
//    -> that word is discarded; next imem_addr=0x100; id_valid=0 until the 0x100 word.
//  6 Reset_L=0 mid-REQ with a same-cycle ack -> all outputs at reset values;
//    imem_addr=RESET_PC two cycles later; pc at 0xFFFF_FFFF_FFFF_FFFC with ack -> next addr 0.

Source files
------------

// File: rtl/fetch_decode_stage_if.sv
// Instruction memory fetch channel.
// Fetch side drives req/addr; memory answers with ack/rdata.
interface fetch_decode_stage_if;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_decode_stage.sv
// LEGv8 fetch/decode front end: PC, imem handshake,
// ID register with skid entry, immediate-type decode.
module fetch_decode_stage #(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter logic [63:0] PC_INC   = 64'd4
) (
  input  logic                        CLK,
  input  logic                        Reset_L,
  fetch_decode_stage_if.master        imem,
  input  logic                        branch_taken,
  input  logic [63:0]                 branch_target,
  input  logic                        stall,
  output logic                        id_valid,
  output logic [63:0]                 id_pc,
  output logic [31:0]                 id_instr,
  output logic [25:0]                 Imm25,
  output logic [2:0]                  SignOp
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    HOLD
  } state_t;

  state_t      state, state_d;
  logic [63:0] pc, pc_d;
  logic [63:0] faddr;
  logic        kill;
  logic [63:0] skid_pc;
  logic [31:0] skid_instr;
  logic        take, load_id, load_skid, unskid;
  logic        ack;

  assign ack           = imem.imem_ack;
  assign imem.imem_req  = (state == REQ);
  assign imem.imem_addr = faddr;
  assign Imm25          = id_instr[25:0];

  // Fetch FSM state register.
  always_ff @(posedge CLK) begin
    if (!Reset_L) state <= IDLE;
    else          state <= state_d;
  end

  // Next state, word routing and next PC.
  always_comb begin
    state_d   = state;
    take      = 1'b0;
    load_id   = 1'b0;
    load_skid = 1'b0;
    unskid    = 1'b0;
    pc_d      = pc;
    unique case (state)
      IDLE: state_d = REQ;
      REQ: begin
        if (ack && !kill && !branch_taken) begin
          take = 1'b1;
          if (stall && id_valid) begin
            load_skid = 1'b1;
            state_d   = HOLD;
          end else begin
            load_id = 1'b1;
          end
        end
      end
      HOLD: begin
        if (branch_taken) begin
          state_d = REQ;
        end else if (!stall) begin
          unskid  = 1'b1;
          state_d = REQ;
        end
      end
      default: state_d = IDLE;
    endcase
    if (branch_taken) pc_d = branch_target;
    else if (take)    pc_d = pc + PC_INC;
  end

  // PC, fetch address, kill flag, skid and ID registers.
  always_ff @(posedge CLK) begin
    if (!Reset_L) begin
      pc         <= RESET_PC;
      faddr      <= RESET_PC;
      kill       <= 1'b0;
      skid_pc    <= '0;
      skid_instr <= '0;
      id_valid   <= 1'b0;
      id_pc      <= '0;
      id_instr   <= '0;
    end else begin
      pc <= pc_d;
      if (!(state == REQ && !ack)) faddr <= pc_d;
      if (state == REQ) begin
        if (ack)               kill <= 1'b0;
        else if (branch_taken) kill <= 1'b1;
      end
      if (load_skid) begin
        skid_pc    <= faddr;
        skid_instr <= imem.imem_rdata;
      end
      if (branch_taken) begin
        id_valid <= 1'b0;
      end else if (load_id) begin
        id_valid <= 1'b1;
        id_pc    <= faddr;
        id_instr <= imem.imem_rdata;
      end else if (unskid) begin
        id_valid <= 1'b1;
        id_pc    <= skid_pc;
        id_instr <= skid_instr;
      end else if (!stall) begin
        id_valid <= 1'b0;
      end
    end
  end

  // Immediate-type select from the opcode field.
  always_comb begin
    SignOp = 3'b100;
    unique case (1'b1)
      (id_instr[31:26] == 6'b000101) ||
      (id_instr[31:26] == 6'b100101):
        SignOp = 3'b010;
      (id_instr[31:24] == 8'b10110100) ||
      (id_instr[31:24] == 8'b10110101) ||
      (id_instr[31:24] == 8'b01010100):
        SignOp = 3'b011;
      (id_instr[31:21] == 11'b11111000010) ||
      (id_instr[31:21] == 11'b11111000000):
        SignOp = 3'b001;
      (id_instr[31:23] == 9'b110100101) ||
      (id_instr[31:23] == 9'b111100101):
        SignOp = 3'b101;
      (id_instr[31:22] == 10'b1001000100) ||
      (id_instr[31:22] == 10'b1101000100) ||
      (id_instr[31:22] == 10'b1001001000) ||
      (id_instr[31:22] == 10'b1011001000):
        SignOp = 3'b000;
      default:
        SignOp = 3'b100;
    endcase
  end

endmodule

// File: tb/tb_fetch_decode_stage.sv
// Directed bench for fetch_decode_stage.
// Inputs change 1ns after posedge; outputs checked there.
module tb_fetch_decode_stage;

  logic        CLK = 1'b0;
  logic        Reset_L;
  logic        branch_taken;
  logic [63:0] branch_target;
  logic        stall;
  logic        id_valid;
  logic [63:0] id_pc;
  logic [31:0] id_instr;
  logic [25:0] Imm25;
  logic [2:0]  SignOp;

  int n_cmp = 0;
  int n_bad = 0;

  fetch_decode_stage_if imem ();

  fetch_decode_stage dut (
    .CLK           (CLK),
    .Reset_L       (Reset_L),
    .imem          (imem),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .stall         (stall),
    .id_valid      (id_valid),
    .id_pc         (id_pc),
    .id_instr      (id_instr),
    .Imm25         (Imm25),
    .SignOp        (SignOp)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    assert (got === exp)
    else begin
      n_bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic chk_id(input string tag,
                        input logic        v,
                        input logic [63:0] pc,
                        input logic [31:0] ins);
    chk({tag, ".valid"}, {63'd0, id_valid}, {63'd0, v});
    chk({tag, ".pc"}, id_pc, pc);
    chk({tag, ".instr"}, {32'd0, id_instr}, {32'd0, ins});
  endtask

  task automatic chk_if(input string tag,
                        input logic        req,
                        input logic [63:0] addr);
    chk({tag, ".req"}, {63'd0, imem.imem_req}, {63'd0, req});
    chk({tag, ".addr"}, imem.imem_addr, addr);
  endtask

  initial begin
    Reset_L         = 1'b0;
    stall           = 1'b0;
    branch_taken    = 1'b0;
    branch_target   = 64'h0;
    imem.imem_ack   = 1'b0;
    imem.imem_rdata = 32'h0;
    tick();
    tick();
    chk_id("rst", 1'b0, 64'h0, 32'h0);
    chk("rst.signop", {61'd0, SignOp}, 64'd4);
    chk("rst.imm", {38'd0, Imm25}, 64'h0);
    chk_if("rst", 1'b0, 64'h0);

    // 1: back-to-back ADDI fetches
    Reset_L = 1'b1;
    tick();
    chk_if("t1.idle2req", 1'b1, 64'h0);
    imem.imem_ack   = 1'b1;
    imem.imem_rdata = 32'h91000421;
    tick();
    chk_id("t1.w0", 1'b1, 64'h0, 32'h91000421);
    chk("t1.signop", {61'd0, SignOp}, 64'd0);
    chk("t1.imm", {38'd0, Imm25}, 64'h1000421);
    chk_if("t1.a4", 1'b1, 64'h4);
    tick();
    chk_id("t1.w1", 1'b1, 64'h4, 32'h91000421);
    chk_if("t1.a8", 1'b1, 64'h8);
    tick();
    chk_id("t1.w2", 1'b1, 64'h8, 32'h91000421);
    chk_if("t1.a12", 1'b1, 64'hC);

    // 2: B then MOVZ
    imem.imem_rdata = 32'h14000004;
    tick();
    chk_id("t2.b", 1'b1, 64'hC, 32'h14000004);
    chk("t2.b.signop", {61'd0, SignOp}, 64'd2);
    chk("t2.b.imm", {38'd0, Imm25}, 64'h4);
    imem.imem_rdata = 32'hD2A24680;
    tick();
    chk_id("t2.movz", 1'b1, 64'h10, 32'hD2A24680);
    chk("t2.movz.signop", {61'd0, SignOp}, 64'd5);
    chk("t2.movz.imm", {38'd0, Imm25}, 64'h2A24680);
    chk_if("t2.a20", 1'b1, 64'h14);

    // 3: ack delayed three cycles
    imem.imem_ack = 1'b0;
    tick();
    chk("t3.wait1.valid", {63'd0, id_valid}, 64'd0);
    chk_if("t3.wait1", 1'b1, 64'h14);
    tick();
    chk("t3.wait2.valid", {63'd0, id_valid}, 64'd0);
    chk_if("t3.wait2", 1'b1, 64'h14);
    tick();
    chk("t3.wait3.valid", {63'd0, id_valid}, 64'd0);
    chk_if("t3.wait3", 1'b1, 64'h14);
    imem.imem_ack   = 1'b1;
    imem.imem_rdata = 32'h91000421;
    tick();
    chk_id("t3.got", 1'b1, 64'h14, 32'h91000421);
    chk_if("t3.a24", 1'b1, 64'h18);

    // 4: stall two cycles, word goes to skid
    stall           = 1'b1;
    imem.imem_rdata = 32'hAAAA0001;
    tick();
    chk_id("t4.s1", 1'b1, 64'h14, 32'h91000421);
    chk("t4.s1.req", {63'd0, imem.imem_req}, 64'd0);
    imem.imem_ack = 1'b0;
    tick();
    chk_id("t4.s2", 1'b1, 64'h14, 32'h91000421);
    chk("t4.s2.req", {63'd0, imem.imem_req}, 64'd0);
    stall = 1'b0;
    tick();
    chk_id("t4.skid", 1'b1, 64'h18, 32'hAAAA0001);
    chk("t4.skid.signop", {61'd0, SignOp}, 64'd4);
    chk_if("t4.a28", 1'b1, 64'h1C);
    imem.imem_ack   = 1'b1;
    imem.imem_rdata = 32'h12345678;
    tick();
    chk_id("t4.next", 1'b1, 64'h1C, 32'h12345678);
    chk_if("t4.a32", 1'b1, 64'h20);

    // 5: redirect with a pending fetch
    imem.imem_ack = 1'b0;
    tick();
    chk("t5.bubble", {63'd0, id_valid}, 64'd0);
    branch_taken  = 1'b1;
    branch_target = 64'h100;
    tick();
    branch_taken = 1'b0;
    chk("t5.br.valid", {63'd0, id_valid}, 64'd0);
    chk_if("t5.br.held", 1'b1, 64'h20);
    tick();
    chk_if("t5.br.held2", 1'b1, 64'h20);
    imem.imem_ack   = 1'b1;
    imem.imem_rdata = 32'h91000421;
    tick();
    chk("t5.kill.valid", {63'd0, id_valid}, 64'd0);
    chk_if("t5.a100", 1'b1, 64'h100);
    imem.imem_rdata = 32'h14000004;
    tick();
    chk_id("t5.tgt", 1'b1, 64'h100, 32'h14000004);
    chk_if("t5.a104", 1'b1, 64'h104);

    // 6: reset mid-fetch with ack, then PC wrap
    Reset_L         = 1'b0;
    imem.imem_rdata = 32'hD2A24680;
    tick();
    chk_id("t6.rst", 1'b0, 64'h0, 32'h0);
    chk("t6.rst.signop", {61'd0, SignOp}, 64'd4);
    chk("t6.rst.req", {63'd0, imem.imem_req}, 64'd0);
    Reset_L       = 1'b1;
    imem.imem_ack = 1'b0;
    tick();
    chk_if("t6.restart", 1'b1, 64'h0);
    branch_taken    = 1'b1;
    branch_target   = 64'hFFFF_FFFF_FFFF_FFFC;
    imem.imem_ack   = 1'b1;
    imem.imem_rdata = 32'h91000421;
    tick();
    branch_taken = 1'b0;
    chk("t6.br.valid", {63'd0, id_valid}, 64'd0);
    chk_if("t6.atop", 1'b1, 64'hFFFF_FFFF_FFFF_FFFC);
    tick();
    chk_id("t6.top", 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 32'h91000421);
    chk_if("t6.wrap", 1'b1, 64'h0);
    imem.imem_ack = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
